// File: rtl/risc_trace_monitor_pkg.sv
// Shared types for the commit-trace monitor: record layout, session states, width helper.
package trace_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data_m;
    logic            mem_read;
    logic            mem_write;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } trace_state_e;

  function automatic int rec_w(int xlen);
    return 4 * xlen + 2;
  endfunction

  localparam int REC_W = rec_w(XLEN);
endpackage

// File: rtl/risc_trace_monitor_if.sv
// Core commit bus plus valid/ready readout port of the trace monitor.
interface risc_trace_monitor_if #(parameter int XLEN = 32) ();
  logic              stall_in;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   instr_in;
  logic [XLEN-1:0]   alu_result_in;
  logic [XLEN-1:0]   read_data_m_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              rd_valid;
  logic              rd_ready;
  logic [4*XLEN+1:0] rd_data;

  modport mon (
    input  stall_in, pc_in, instr_in, alu_result_in, read_data_m_in,
           mem_read_in, mem_write_in, rd_ready,
    output rd_valid, rd_data
  );

  modport host (
    output stall_in, pc_in, instr_in, alu_result_in, read_data_m_in,
           mem_read_in, mem_write_in, rd_ready,
    input  rd_valid, rd_data
  );
endinterface

// File: rtl/risc_trace_monitor_fifo.sv
// Synchronous trace FIFO; on overwrite_i a push into a full FIFO discards the oldest entry.
module trace_fifo #(
  parameter int W     = 130,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     overwrite_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          do_pop, wr, drop_old, adv_r;

  assign full_o   = (level_q == (AW+1)'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign level_o  = level_q;
  assign do_pop   = pop_i && !empty_o;
  assign wr       = push_i && (!full_o || do_pop || overwrite_i);
  assign drop_old = push_i && full_o && !do_pop && overwrite_i;
  assign adv_r    = do_pop || drop_old;
  // Gate with empty so the head reads zero out of reset and between sessions.
  assign dout_o   = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr)    wptr_q <= wptr_q + AW'(1);
      if (adv_r) rptr_q <= rptr_q + AW'(1);
      case ({wr, adv_r})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !clr_i) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/risc_trace_monitor.sv
// Commit-trace monitor: session FSM, PC trigger and saturating event counters around trace_fifo.
module risc_trace_monitor
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   RST_n,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic                   wrap_mode,
  risc_trace_monitor_if.mon      bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       commit_cnt,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);
  localparam int RW = rec_w(XLEN);
  localparam int LW = $clog2(DEPTH) + 1;

  trace_state_e   state_q;
  logic [CNT_W-1:0] commit_cnt_q, stall_cnt_q, drop_cnt_q;
  logic [RW-1:0]  rec;
  logic           commit, hit, push, in_cap, do_pop, drop, freeze_full;
  logic           f_full, f_empty;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign commit = !bus.stall_in;
  assign hit    = (bus.pc_in == trig_pc);
  assign rec    = {bus.pc_in, bus.instr_in, bus.alu_result_in, bus.read_data_m_in,
                   bus.mem_read_in, bus.mem_write_in};
  assign push   = !arm && !stop && commit &&
                  ((state_q == CAPTURE) || ((state_q == ARMED) && hit));
  assign in_cap = (state_q == CAPTURE) && !arm && !stop;
  assign do_pop = !f_empty && bus.rd_ready;
  assign drop   = push && f_full && !do_pop;
  // Stop-on-full: freeze once a push leaves the FIFO full (or is refused because it is full).
  assign freeze_full = push && !wrap_mode &&
                       (f_full || ((level == LW'(DEPTH - 1)) && !do_pop));

  trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (RST_n),
    .clr_i      (arm),
    .push_i     (push),
    .pop_i      (bus.rd_ready),
    .overwrite_i(wrap_mode),
    .din_i      (rec),
    .dout_o     (bus.rd_data),
    .full_o     (f_full),
    .empty_o    (f_empty),
    .level_o    (level)
  );

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      commit_cnt_q <= '0;
      stall_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else if (arm) begin
      state_q      <= trig_en ? ARMED : CAPTURE;
      commit_cnt_q <= '0;
      stall_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      case (state_q)
        ARMED:   if (stop) state_q <= FROZEN;
                 else if (commit && hit) state_q <= CAPTURE;
        CAPTURE: if (stop || freeze_full) state_q <= FROZEN;
        default: state_q <= state_q;
      endcase
      if (in_cap) begin
        if (commit) commit_cnt_q <= sat_inc(commit_cnt_q);
        else        stall_cnt_q  <= sat_inc(stall_cnt_q);
        if (drop)   drop_cnt_q   <= sat_inc(drop_cnt_q);
      end
    end
  end

  assign bus.rd_valid = !f_empty;
  assign state_o      = state_q;
  assign commit_cnt   = commit_cnt_q;
  assign stall_cnt    = stall_cnt_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_risc_trace_monitor.sv
// Self-checking bench for risc_trace_monitor: scoreboard of expected records plus table-driven trigger vectors.
module tb_risc_trace_monitor;
  import trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic            clk, RST_n, arm, stop, trig_en, wrap_mode;
  logic [31:0]     trig_pc;
  logic [4:0]      level;
  logic [1:0]      state_o;
  logic [CW-1:0]   commit_cnt, stall_cnt, drop_cnt;
  int              pass_n, total_n;
  logic [REC_W-1:0] sb[$];

  risc_trace_monitor_if #(.XLEN(32)) bus ();

  risc_trace_monitor #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .RST_n(RST_n), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .wrap_mode(wrap_mode), .bus(bus), .level(level),
    .state_o(state_o), .commit_cnt(commit_cnt), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [31:0] pc;
    logic        psh;
    logic [1:0]  st;
    logic [4:0]  lvl;
  } vec_t;
  vec_t tv[5];

  function automatic logic [REC_W-1:0] mkrec(logic [31:0] pc);
    trace_rec_t r;
    r.pc          = pc;
    r.instr       = pc ^ 32'hA5A5_0F0F;
    r.alu_result  = pc + 32'd7;
    r.read_data_m = ~pc;
    r.mem_read    = pc[2];
    r.mem_write   = pc[3];
    return r;
  endfunction

  task automatic chk(string nm, logic [REC_W-1:0] got, logic [REC_W-1:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic stall, logic [31:0] pc);
    bus.stall_in       = stall;
    bus.pc_in          = pc;
    bus.instr_in       = pc ^ 32'hA5A5_0F0F;
    bus.alu_result_in  = pc + 32'd7;
    bus.read_data_m_in = ~pc;
    bus.mem_read_in    = pc[2];
    bus.mem_write_in   = pc[3];
    tick();
  endtask

  task automatic do_arm(logic te, logic wm);
    trig_en = te; wrap_mode = wm; arm = 1'b1;
    drive(1'b1, 32'h0);
    arm = 1'b0;
  endtask

  // Pops n records, comparing each against the scoreboard head; ends expecting an empty FIFO.
  task automatic drain(int n, string nm);
    logic [REC_W-1:0] e;
    bus.rd_ready = 1'b1;
    bus.stall_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (!bus.rd_valid || sb.size() == 0) begin
        chk({nm, "_timeout"}, REC_W'(bus.rd_valid), REC_W'(sb.size() != 0));
        break;
      end
      e = sb.pop_front();
      chk(nm, bus.rd_data, e);
      tick();
    end
    bus.rd_ready = 1'b0;
    chk({nm, "_empty"}, REC_W'(bus.rd_valid), '0);
  endtask

  initial begin
    pass_n = 0; total_n = 0;
    arm = 0; stop = 0; trig_en = 0; trig_pc = 32'h40; wrap_mode = 0;
    bus.rd_ready = 0; bus.stall_in = 1; bus.pc_in = 0; bus.instr_in = 0;
    bus.alu_result_in = 0; bus.read_data_m_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
    RST_n = 1'b1;
    #1 RST_n = 1'b0;
    #12 RST_n = 1'b1;
    tick();

    chk("rst_level", REC_W'(level), '0);
    chk("rst_valid", REC_W'(bus.rd_valid), '0);
    chk("rst_data", bus.rd_data, '0);
    chk("rst_state", REC_W'(state_o), REC_W'(IDLE));
    chk("rst_cnt", REC_W'({commit_cnt, stall_cnt, drop_cnt}), '0);

    // Stall filtering
    do_arm(1'b0, 1'b0);
    chk("flt_state", REC_W'(state_o), REC_W'(CAPTURE));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h100 + 32'(4*i)); sb.push_back(mkrec(32'h100 + 32'(4*i)));
    end
    drive(1'b1, 32'h200);
    drive(1'b1, 32'h204);
    drive(1'b0, 32'h10C); sb.push_back(mkrec(32'h10C));
    chk("flt_level", REC_W'(level), REC_W'(4));
    chk("flt_commit", REC_W'(commit_cnt), REC_W'(4));
    chk("flt_stall", REC_W'(stall_cnt), REC_W'(2));
    drain(4, "flt_rd");

    // Trigger: stall at the trigger PC must not fire
    tv[0] = '{1'b0, 32'h30, 1'b0, 2'd1, 5'd0};
    tv[1] = '{1'b1, 32'h40, 1'b0, 2'd1, 5'd0};
    tv[2] = '{1'b0, 32'h34, 1'b0, 2'd1, 5'd0};
    tv[3] = '{1'b0, 32'h40, 1'b1, 2'd2, 5'd1};
    tv[4] = '{1'b0, 32'h44, 1'b1, 2'd2, 5'd2};
    trig_pc = 32'h40;
    do_arm(1'b1, 1'b0);
    chk("trg_armed", REC_W'(state_o), REC_W'(ARMED));
    for (int i = 0; i < 5; i++) begin
      drive(tv[i].stall, tv[i].pc);
      if (tv[i].psh) sb.push_back(mkrec(tv[i].pc));
      chk($sformatf("trg_state%0d", i), REC_W'(state_o), REC_W'(tv[i].st));
      chk($sformatf("trg_level%0d", i), REC_W'(level), REC_W'(tv[i].lvl));
    end
    drain(2, "trg_rd");

    // Stop-on-full
    do_arm(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h1000 + 32'(4*i));
      if (i < DEPTH) sb.push_back(mkrec(32'h1000 + 32'(4*i)));
      if (i == DEPTH - 1) begin
        chk("sof_state16", REC_W'(state_o), REC_W'(FROZEN));
        chk("sof_level16", REC_W'(level), REC_W'(DEPTH));
      end
    end
    chk("sof_level", REC_W'(level), REC_W'(DEPTH));
    chk("sof_drop", REC_W'(drop_cnt), '0);
    chk("sof_head", bus.rd_data, mkrec(32'h1000));
    drain(DEPTH, "sof_rd");

    // Wrap mode
    do_arm(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h2000 + 32'(4*i));
      sb.push_back(mkrec(32'h2000 + 32'(4*i)));
      if (sb.size() > DEPTH) void'(sb.pop_front());
    end
    chk("wrp_level", REC_W'(level), REC_W'(DEPTH));
    chk("wrp_drop", REC_W'(drop_cnt), REC_W'(4));
    chk("wrp_head", bus.rd_data, mkrec(32'h2010));
    bus.rd_ready = 1'b1;
    chk("wrp_pp_pop", bus.rd_data, sb[0]);
    drive(1'b0, 32'h3000);
    void'(sb.pop_front());
    sb.push_back(mkrec(32'h3000));
    bus.rd_ready = 1'b0;
    chk("wrp_pp_level", REC_W'(level), REC_W'(DEPTH));
    chk("wrp_pp_drop", REC_W'(drop_cnt), REC_W'(4));
    drain(DEPTH, "wrp_rd");

    // Stop pulse, then arm beating a simultaneous stop
    stop = 1'b1;
    drive(1'b0, 32'h5000);
    stop = 1'b0;
    chk("stp_state", REC_W'(state_o), REC_W'(FROZEN));
    chk("stp_level", REC_W'(level), '0);
    stop = 1'b1;
    do_arm(1'b0, 1'b0);
    stop = 1'b0;
    chk("arm_prio", REC_W'(state_o), REC_W'(CAPTURE));

    // Reset mid-capture, observed before the next edge
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h6000 + 32'(4*i));
    chk("mid_level_pre", REC_W'(level), REC_W'(5));
    #2 RST_n = 1'b0;
    #1;
    chk("mid_level", REC_W'(level), '0);
    chk("mid_valid", REC_W'(bus.rd_valid), '0);
    chk("mid_state", REC_W'(state_o), REC_W'(IDLE));
    chk("mid_cnt", REC_W'({commit_cnt, stall_cnt, drop_cnt}), '0);
    RST_n = 1'b1;
    sb.delete();
    tick();

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/risc_trace_monitor.md
Name: risc_trace_monitor

Overview:
- Synthesizable on-chip commit-trace monitor for the single-cycle RISC-V core with cache.
- Samples the core's per-cycle commit signals, filters out stalled cycles, and buffers committed-instruction records in a parametrised trace FIFO.
- Supports a PC trigger, stop-on-full or wrap mode, event counters, and a valid/ready readout port for a debug host or testbench.

Parameters:
- XLEN, 32, data/address width of PC, instruction, ALU result and read data.
- DEPTH, 16, trace FIFO entries; power of 2, >=2.
- CNT_W, 32, width of each event counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- RST_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse: clear FIFO/counters, start a capture session.
- stop  in  1  one-cycle pulse: force FROZEN.
- trig_en  in  1  1 = wait for trig_pc before capturing.
- trig_pc  in  XLEN  trigger PC.
- wrap_mode  in  1  1 = overwrite oldest when full; 0 = stop when full.
- stall_in  in  1  core Stall; a cycle with stall_in=0 is a commit cycle.
- pc_in  in  XLEN  committed PC.
- instr_in  in  XLEN  committed instruction.
- alu_result_in  in  XLEN  ALUResult.
- read_data_m_in  in  XLEN  cache ReadData.
- mem_read_in  in  1  MemRead.
- mem_write_in  in  1  MemWrite.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_ready  in  1  host accepts rd_data.
- rd_data  out  4*XLEN+2  oldest record {pc, instr, alu_result, read_data_m, mem_read, mem_write}.
- level  out  $clog2(DEPTH)+1  entries held.
- state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3.
- commit_cnt  out  CNT_W  commit cycles seen in CAPTURE.
- stall_cnt  out  CNT_W  stall cycles seen in CAPTURE.
- drop_cnt  out  CNT_W  records lost (overwritten or refused).

Behaviour:
- Reset (async, RST_n=0):
  - state IDLE; FIFO empty; level=0; rd_valid=0; rd_data=0; all counters 0.
- State machine:
  - IDLE/FROZEN + arm:
    - Clear FIFO and counters.
    - Go to ARMED if trig_en, else CAPTURE.
  - ARMED:
    - Commit cycle with pc_in==trig_pc: go to CAPTURE, and push that same record this cycle.
    - Stall cycles never trigger.
  - CAPTURE:
    - Each commit cycle pushes one record and increments commit_cnt.
    - Each stall cycle increments stall_cnt and pushes nothing.
  - stop in ARMED/CAPTURE: go to FROZEN next edge; no push on that cycle.
  - arm while in ARMED/CAPTURE: restart the session (clear and re-arm). arm has priority over stop.
- Full handling:
  - wrap_mode=1, push while full, no pop: oldest entry discarded, new entry written, level stays DEPTH, drop_cnt+1.
  - wrap_mode=0, push that makes level==DEPTH: record written, go to FROZEN next edge.
  - Any push attempted while full and frozen-bound: refused, drop_cnt+1.
- Push and pop in the same cycle:
  - Both succeed; level unchanged.
  - Applies when full too; no drop counted.
- Readout:
  - Pop when rd_valid && rd_ready. Allowed in every state, including FROZEN.
  - Pop on empty is ignored.
  - Latency: a record pushed at edge N appears on rd_data after edge N if the FIFO was empty.
  - rd_data is stable while rd_valid && !rd_ready.
- Counters saturate at 2^CNT_W-1 and do not wrap. They update only in CAPTURE.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from level.

Decomposition:
- Shared package trace_pkg:
  - trace_rec_t packed struct (pc, instr, alu_result, read_data_m, mem_read, mem_write).
  - trace_state_e enum (IDLE, ARMED, CAPTURE, FROZEN).
  - REC_W localparam function of XLEN.
- One sub-module, trace_fifo:
  - Sync FIFO with an overwrite-when-full input, exposing push, pop, full, empty, level, head data.
  - The FSM, trigger and counters stay in risc_trace_monitor.

Test Plan:
- Reset mid-capture: 5 commits pushed, then RST_n=0 for 1 ns between edges -> level=0, rd_valid=0, state_o=0 immediately, counters 0.
- Stall filtering: arm, trig_en=0, 3 commits + 2 stall cycles + 1 commit -> level=4, commit_cnt=4, stall_cnt=2, rd_data pc sequence in order.
- Trigger: trig_en=1, trig_pc=0x40, commits at PC 0x30,0x34,0x40,0x44 -> state ARMED until 0x40, FIFO holds 0x40,0x44 only.
- Stop-on-full: wrap_mode=0, DEPTH=16, 20 commits, rd_ready=0 -> level=16, state_o=3 after 16th push, drop_cnt=0, first entry = first PC.
- Wrap: wrap_mode=1, 20 commits, rd_ready=0 -> level=16, drop_cnt=4, head = 5th PC; then drain 16 with rd_ready=1 -> rd_valid=0.
- Simultaneous push/pop at full with wrap_mode=1 -> level stays 16, drop_cnt unchanged, popped record = oldest.
